// File: rtl/alarm_pkg.sv
// Shared state codes, BCD pair type, digit limits and default tick counts for the alarm controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    SET_TIME_H = 3'd1,
    SET_TIME_M = 3'd2,
    SET_ALM_H  = 3'd3,
    SET_ALM_M  = 3'd4,
    RINGING    = 3'd5,
    SNOOZE     = 3'd6
  } state_t;

  typedef struct packed {
    logic [3:0] hi;
    logic [3:0] lo;
  } bcd2_t;

  localparam bcd2_t HOUR_MAX = 8'h23;
  localparam bcd2_t MIN_MAX  = 8'h59;

  localparam int RING_TICKS_DEF   = 60;
  localparam int SNOOZE_TICKS_DEF = 300;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/bcd2_inc.sv
// Two-digit BCD increment with wrap to 00 at a BCD limit; purely combinational.
module bcd2_inc
  import alarm_pkg::*;
(
  input  bcd2_t cur,
  input  bcd2_t lim,
  output bcd2_t nxt
);

  always_comb begin
    nxt = cur;
    // values at or past the limit wrap, so a corrupt pair recovers on the next press
    if ({cur.hi, cur.lo} >= {lim.hi, lim.lo}) begin
      nxt = '0;
    end else if (cur.lo >= 4'd9) begin
      nxt.hi = cur.hi + 4'd1;
      nxt.lo = 4'd0;
    end else begin
      nxt.lo = cur.lo + 4'd1;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock mode FSM: time/alarm editing, time load strobe, ring/snooze sequencing.
// All outputs registered, one cycle from button/trigger; pulse inputs, no backpressure.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_TICKS   = RING_TICKS_DEF,
  parameter int SNOOZE_TICKS = SNOOZE_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_snooze,
  input  logic       btn_off,
  input  logic       btn_alm_en,
  input  logic [3:0] H2,
  input  logic [3:0] H1,
  input  logic [3:0] M2,
  input  logic [3:0] M1,
  input  logic [5:0] Sec,
  output logic       ld,
  output logic [3:0] ld_H2,
  output logic [3:0] ld_H1,
  output logic [3:0] ld_M2,
  output logic [3:0] ld_M1,
  output logic [3:0] AH2,
  output logic [3:0] AH1,
  output logic [3:0] AM2,
  output logic [3:0] AM1,
  output logic       alm_en,
  output logic       buzz,
  output logic [2:0] state
);

  localparam int            CW          = cnt_width(RING_TICKS, SNOOZE_TICKS);
  localparam logic [CW-1:0] RING_LAST   = CW'(RING_TICKS - 1);
  localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_TICKS - 1);

  state_t        st;
  logic [CW-1:0] cnt;
  logic          fired;
  logic          min_match;
  logic          trig;
  logic          p_off, p_snooze, p_mode, p_alm, p_inc;
  bcd2_t         hr_cur, hr_nxt, mn_cur, mn_nxt;

  assign state = st;

  // one button wins per cycle: off > snooze > mode > alm_en > inc
  assign p_off    = btn_off;
  assign p_snooze = btn_snooze & ~btn_off;
  assign p_mode   = btn_mode & ~btn_snooze & ~btn_off;
  assign p_alm    = btn_alm_en & ~btn_mode & ~btn_snooze & ~btn_off;
  assign p_inc    = btn_inc & ~btn_alm_en & ~btn_mode & ~btn_snooze & ~btn_off;

  assign min_match = ({H2, H1, M2, M1} == {AH2, AH1, AM2, AM1});
  assign trig      = (st == RUN) && alm_en && min_match && (Sec == 6'd0) && !fired;

  always_comb begin
    hr_cur = {ld_H2, ld_H1};
    mn_cur = {ld_M2, ld_M1};
    if (st == SET_ALM_H) hr_cur = {AH2, AH1};
    if (st == SET_ALM_M) mn_cur = {AM2, AM1};
  end

  bcd2_inc u_hr_inc (.cur(hr_cur), .lim(HOUR_MAX), .nxt(hr_nxt));
  bcd2_inc u_mn_inc (.cur(mn_cur), .lim(MIN_MAX),  .nxt(mn_nxt));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= RUN;
      cnt    <= '0;
      fired  <= 1'b0;
      ld     <= 1'b0;
      buzz   <= 1'b0;
      alm_en <= 1'b0;
      ld_H2  <= '0;
      ld_H1  <= '0;
      ld_M2  <= '0;
      ld_M1  <= '0;
      AH2    <= '0;
      AH1    <= '0;
      AM2    <= '0;
      AM1    <= '0;
    end else begin
      ld <= 1'b0;
      // fired stays set for the rest of the alarm minute so off cannot re-arm it
      if (trig) fired <= 1'b1;
      else if (!min_match) fired <= 1'b0;

      case (st)
        RUN: begin
          if (trig) begin
            st   <= RINGING;
            buzz <= 1'b1;
            cnt  <= '0;
          end else if (p_mode) begin
            st <= SET_TIME_H;
            {ld_H2, ld_H1, ld_M2, ld_M1} <= {H2, H1, M2, M1};
          end else if (p_alm) begin
            alm_en <= ~alm_en;
          end
        end
        SET_TIME_H: begin
          if (p_mode) st <= SET_TIME_M;
          else if (p_inc) {ld_H2, ld_H1} <= hr_nxt;
        end
        SET_TIME_M: begin
          if (p_mode) begin
            st <= SET_ALM_H;
            ld <= 1'b1;
          end else if (p_inc) begin
            {ld_M2, ld_M1} <= mn_nxt;
          end
        end
        SET_ALM_H: begin
          if (p_mode) st <= SET_ALM_M;
          else if (p_inc) {AH2, AH1} <= hr_nxt;
        end
        SET_ALM_M: begin
          if (p_mode) st <= RUN;
          else if (p_inc) {AM2, AM1} <= mn_nxt;
        end
        RINGING: begin
          if (p_off) begin
            st   <= RUN;
            buzz <= 1'b0;
          end else if (p_snooze) begin
            st   <= SNOOZE;
            buzz <= 1'b0;
            cnt  <= '0;
          end else if (tick) begin
            if (cnt == RING_LAST) begin
              st   <= RUN;
              buzz <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        SNOOZE: begin
          if (p_off) begin
            st <= RUN;
          end else if (tick) begin
            if (cnt == SNOOZE_LAST) begin
              st   <= RINGING;
              buzz <= 1'b1;
              cnt  <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          st   <= RUN;
          buzz <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Testbench for alarm_ctrl with an integer-level reference model and a simple time counter.
module tb_alarm_ctrl;

  localparam int RING = 60;
  localparam int SNZ  = 300;
  localparam int S_RUN = 0, S_STH = 1, S_STM = 2, S_SAH = 3, S_SAM = 4, S_RING = 5, S_SNZ = 6;
  localparam logic [4:0] B_OFF = 5'b10000, B_SNZ = 5'b01000, B_MODE = 5'b00100,
                         B_AE = 5'b00010, B_INC = 5'b00001;

  logic       clk = 1'b0;
  logic       rst, tick, btn_mode, btn_inc, btn_snooze, btn_off, btn_alm_en;
  logic [3:0] H2, H1, M2, M1;
  logic [5:0] Sec;
  logic       ld, alm_en, buzz;
  logic [3:0] ld_H2, ld_H1, ld_M2, ld_M1, AH2, AH1, AM2, AM1;
  logic [2:0] state;

  int cur_h, cur_m, cur_s;
  int th, tm, ts;
  int m_st, m_cnt, m_eh, m_em, m_ah, m_am;
  bit m_en, m_fired, m_ld, m_buzz;
  int checks, failures, ld_pulses;
  logic [15:0] ld_seen;

  always #5 clk = ~clk;

  assign H2  = 4'(cur_h / 10);
  assign H1  = 4'(cur_h % 10);
  assign M2  = 4'(cur_m / 10);
  assign M1  = 4'(cur_m % 10);
  assign Sec = 6'(cur_s);

  alarm_ctrl #(.RING_TICKS(RING), .SNOOZE_TICKS(SNZ)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_snooze(btn_snooze),
    .btn_off(btn_off), .btn_alm_en(btn_alm_en),
    .H2(H2), .H1(H1), .M2(M2), .M1(M1), .Sec(Sec),
    .ld(ld), .ld_H2(ld_H2), .ld_H1(ld_H1), .ld_M2(ld_M2), .ld_M1(ld_M1),
    .AH2(AH2), .AH1(AH1), .AM2(AM2), .AM1(AM1),
    .alm_en(alm_en), .buzz(buzz), .state(state)
  );

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_RUN; m_cnt = 0; m_eh = 0; m_em = 0; m_ah = 0; m_am = 0;
    m_en = 0; m_fired = 0; m_ld = 0; m_buzz = 0;
  endtask

  // Next outputs from this cycle's inputs, time held as plain hour/minute numbers.
  task automatic model_step();
    bit match, trig, off, snz, mode, ae, inc;
    match = (cur_h == m_ah) && (cur_m == m_am);
    trig  = (m_st == S_RUN) && m_en && match && (cur_s == 0) && !m_fired;
    off   = btn_off;
    snz   = btn_snooze && !off;
    mode  = btn_mode && !off && !snz;
    ae    = btn_alm_en && !off && !snz && !btn_mode;
    inc   = btn_inc && !off && !snz && !btn_mode && !btn_alm_en;
    m_ld  = 0;
    if (trig) m_fired = 1;
    else if (!match) m_fired = 0;
    case (m_st)
      S_RUN: begin
        if (trig) begin m_st = S_RING; m_cnt = 0; end
        else if (mode) begin m_st = S_STH; m_eh = cur_h; m_em = cur_m; end
        else if (ae) m_en = !m_en;
      end
      S_STH: if (mode) m_st = S_STM; else if (inc) m_eh = (m_eh + 1) % 24;
      S_STM: if (mode) begin m_st = S_SAH; m_ld = 1; end else if (inc) m_em = (m_em + 1) % 60;
      S_SAH: if (mode) m_st = S_SAM; else if (inc) m_ah = (m_ah + 1) % 24;
      S_SAM: if (mode) m_st = S_RUN; else if (inc) m_am = (m_am + 1) % 60;
      S_RING: begin
        if (off) m_st = S_RUN;
        else if (snz) begin m_st = S_SNZ; m_cnt = 0; end
        else if (tick) begin m_cnt++; if (m_cnt == RING) m_st = S_RUN; end
      end
      S_SNZ: begin
        if (off) m_st = S_RUN;
        else if (tick) begin m_cnt++; if (m_cnt == SNZ) begin m_st = S_RING; m_cnt = 0; end end
      end
      default: m_st = S_RUN;
    endcase
    m_buzz = (m_st == S_RING);
  endtask

  // One clock: drive inputs, advance the time counter, step the model, compare every output.
  task automatic cyc(input logic t, input logic [4:0] b);
    @(negedge clk); #1;
    cur_h = th; cur_m = tm; cur_s = ts;
    tick = t;
    {btn_off, btn_snooze, btn_mode, btn_alm_en, btn_inc} = b;
    if (m_ld) begin
      th = m_eh; tm = m_em; ts = 0;
    end else if (t) begin
      ts++;
      if (ts == 60) begin
        ts = 0; tm++;
        if (tm == 60) begin tm = 0; th = (th + 1) % 24; end
      end
    end
    @(posedge clk); #1;
    if (rst) model_step(); else model_reset();
    if (ld) begin ld_pulses++; ld_seen = {ld_H2, ld_H1, ld_M2, ld_M1}; end
    chk("state", 16'(state), 16'(m_st));
    chk("buzz", 16'(buzz), 16'(m_buzz));
    chk("ld", 16'(ld), 16'(m_ld));
    chk("edit_digits", {ld_H2, ld_H1, ld_M2, ld_M1}, {bcd(m_eh), bcd(m_em)});
    chk("alarm_digits", {AH2, AH1, AM2, AM1}, {bcd(m_ah), bcd(m_am)});
    chk("alm_en", 16'(alm_en), 16'(m_en));
  endtask

  task automatic idle();
    cyc(1'b0, 5'b0);
  endtask

  task automatic press(input logic [4:0] b);
    cyc(1'b0, b);
  endtask

  // Walk the time to 07:30:00 and let the trigger happen.
  task automatic ring_up();
    th = 7; tm = 29; ts = 59;
    idle();
    cyc(1'b1, 5'b0);
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete within 2000000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; failures = 0; ld_pulses = 0; ld_seen = '0;
    rst = 1'b0; tick = 1'b0;
    {btn_off, btn_snooze, btn_mode, btn_alm_en, btn_inc} = 5'b0;
    th = 0; tm = 0; ts = 0; cur_h = 0; cur_m = 0; cur_s = 0;
    model_reset();
    #12;
    chk("reset_state", 16'(state), 16'd0);
    chk("reset_buzz", 16'(buzz), 16'd0);
    chk("reset_ld", 16'(ld), 16'd0);
    chk("reset_alarm", {AH2, AH1, AM2, AM1}, 16'h0000);
    chk("reset_alm_en", 16'(alm_en), 16'd0);
    @(negedge clk); #1; rst = 1'b1;
    idle();

    // 09:58 -> 12:00 edit, exactly one load
    th = 9; tm = 58; ts = 0;
    idle();
    ld_pulses = 0;
    press(B_MODE);
    chk("enter_set_time_h", 16'(state), 16'd1);
    repeat (3) press(B_INC);
    press(B_MODE);
    repeat (2) press(B_INC);
    chk("minute_wrap_keeps_hours", {ld_H2, ld_H1, ld_M2, ld_M1}, 16'h1200);
    press(B_MODE);
    press(B_MODE);
    press(B_MODE);
    idle(); idle();
    chk("ld_pulse_count", 16'(ld_pulses), 16'd1);
    chk("ld_value", ld_seen, 16'h1200);

    // hours wrap 23 -> 00
    th = 23; tm = 5; ts = 0;
    idle();
    press(B_MODE);
    press(B_INC);
    chk("hour_wrap", {ld_H2, ld_H1, ld_M2, ld_M1}, 16'h0005);
    repeat (4) press(B_MODE);

    // alarm 07:30, armed
    press(B_MODE); press(B_MODE); press(B_MODE);
    repeat (7) press(B_INC);
    press(B_MODE);
    repeat (30) press(B_INC);
    press(B_MODE);
    press(B_AE);
    chk("alarm_set", {AH2, AH1, AM2, AM1}, 16'h0730);
    chk("alm_en_set", 16'(alm_en), 16'd1);

    // ring, mode ignored, automatic stop after RING ticks
    ring_up();
    chk("ring_buzz", 16'(buzz), 16'd1);
    chk("ring_state", 16'(state), 16'd5);
    press(B_MODE);
    chk("mode_ignored_ringing", 16'(state), 16'd5);
    repeat (RING - 1) cyc(1'b1, 5'b0);
    chk("ring_before_timeout", 16'(buzz), 16'd1);
    cyc(1'b1, 5'b0);
    chk("ring_timeout_buzz", 16'(buzz), 16'd0);
    chk("ring_timeout_state", 16'(state), 16'd0);
    repeat (3) idle();
    chk("after_timeout_run", 16'(state), 16'd0);

    // off inside the alarm minute must not retrigger
    th = 7; tm = 30; ts = 0;
    idle();
    chk("retrig_new_minute", 16'(buzz), 16'd1);
    press(B_OFF);
    chk("off_state", 16'(state), 16'd0);
    repeat (4) idle();
    chk("no_retrigger_same_minute", 16'(state), 16'd0);

    // snooze, resume after SNZ ticks, then off
    ring_up();
    press(B_SNZ);
    chk("snooze_buzz", 16'(buzz), 16'd0);
    chk("snooze_state", 16'(state), 16'd6);
    repeat (SNZ - 1) cyc(1'b1, 5'b0);
    chk("snooze_before_timeout", 16'(state), 16'd6);
    cyc(1'b1, 5'b0);
    chk("snooze_resume_state", 16'(state), 16'd5);
    chk("snooze_resume_buzz", 16'(buzz), 16'd1);
    press(B_OFF);
    chk("off_after_resume", {13'd0, state}, 16'd0);
    chk("off_after_resume_buzz", 16'(buzz), 16'd0);

    // off + snooze together
    ring_up();
    press(B_OFF | B_SNZ);
    chk("off_beats_snooze", 16'(state), 16'd0);

    // snooze on the timeout tick
    ring_up();
    repeat (RING - 1) cyc(1'b1, 5'b0);
    cyc(1'b1, B_SNZ);
    chk("snooze_beats_timeout", 16'(state), 16'd6);
    press(B_OFF);

    // asynchronous reset while ringing
    ring_up();
    chk("pre_reset_buzz", 16'(buzz), 16'd1);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_buzz", 16'(buzz), 16'd0);
    chk("async_reset_state", 16'(state), 16'd0);
    chk("async_reset_alarm", {AH2, AH1, AM2, AM1}, 16'h0000);
    chk("async_reset_alm_en", 16'(alm_en), 16'd0);
    model_reset();
    idle(); idle();
    @(negedge clk); #2; rst = 1'b1;
    repeat (3) idle();
    chk("post_reset_state", 16'(state), 16'd0);
    chk("post_reset_buzz", 16'(buzz), 16'd0);

    // random traffic, periodically steering the time onto the alarm minute
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] b;
      if (i % 200 == 0) begin th = m_ah; tm = m_am; ts = 0; end
      b = '0;
      for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 11) == 0);
      cyc(1'($urandom_range(0, 1)), b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
